// File: rtl/vss_partition_flow_tdm_rx_if.sv
// Lane and frame bus of the VSS partition-flow TDM receiver.
//   in_data    : lane sample for the current slot (LANE_W bits)
//   in_sync    : frame marker, high in slot 0 only
//   out_data   : published frame, channel c at [c*CH_W +: CH_W]
//   out_valid  : one-cycle pulse when out_data updates
//   locked     : frame alignment held
//   sync_err   : one-cycle pulse on alignment loss
//   parity_err : one-cycle pulse on parity failure
// Modports: master = transmitter/observer side, slave = receiver.
interface vss_partition_flow_tdm_rx_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 1,
  parameter int unsigned LANE_W = 1
);
  logic [LANE_W-1:0]      in_data;
  logic                   in_sync;
  logic [NUM_CH*CH_W-1:0] out_data;
  logic                   out_valid;
  logic                   locked;
  logic                   sync_err;
  logic                   parity_err;

  modport master (
    output in_data, in_sync,
    input  out_data, out_valid, locked, sync_err, parity_err
  );

  modport slave (
    input  in_data, in_sync,
    output out_data, out_valid, locked, sync_err, parity_err
  );
endinterface

// File: rtl/vss_partition_flow_tdm_rx.sv
// TDM receiver for the VSS partitioning flow. Deserialises NUM_CH channels
// of CH_W bits from a LANE_W-bit lane, aligned to in_sync, and publishes all
// channels atomically at frame end.
// Ports:
//   fastclk : lane clock, all logic on the rising edge
//   reset   : asynchronous, active-high
//   bus     : vss_partition_flow_tdm_rx_if.slave (lane in, frame out, status)
// Option macro VSS_PARTITION_FLOW_TDM_PARITY_EN adds a trailing even-parity
// slot (in_data[0] = XOR of every payload lane bit, pad bits included).
module vss_partition_flow_tdm_rx #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 1,
  parameter int unsigned LANE_W = 1
) (
  input logic fastclk,
  input logic reset,
  vss_partition_flow_tdm_rx_if.slave bus
);

  localparam int unsigned SPC = (CH_W + LANE_W - 1) / LANE_W;
  localparam int unsigned PAY = NUM_CH * SPC;
  localparam int unsigned SW  = PAY * LANE_W;
`ifdef VSS_PARTITION_FLOW_TDM_PARITY_EN
  localparam int unsigned FRAME_LEN = PAY + 1;
`else
  localparam int unsigned FRAME_LEN = PAY;
`endif
  localparam int unsigned CW = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  if (FRAME_LEN < 2) begin : g_bad_frame_len
    $error("vss_partition_flow_tdm_rx: FRAME_LEN must be at least 2");
  end

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [CW-1:0]          wr_idx;
  logic                   cap;
  logic                   publish;
  logic                   serr_n;
  logic [SW-1:0]          shadow;
  logic [SW-1:0]          merged;
  logic [NUM_CH*CH_W-1:0] pub;
  logic [NUM_CH*CH_W-1:0] data_q;
  logic                   valid_q;
  logic                   serr_q;
`ifdef VSS_PARTITION_FLOW_TDM_PARITY_EN
  logic                   perr_n;
  logic                   perr_q;
  logic                   par_ok;

  // At the parity slot the whole payload already sits in shadow.
  assign par_ok = ((^shadow) == bus.in_data[0]);
`endif

  // Next-state / control.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    wr_idx  = cnt;
    publish = 1'b0;
    serr_n  = 1'b0;
`ifdef VSS_PARTITION_FLOW_TDM_PARITY_EN
    perr_n  = 1'b0;
`endif
    unique case (state)
      UNLOCKED: begin
        if (bus.in_sync) begin
          cap     = 1'b1;
          wr_idx  = '0;
          cnt_n   = CW'(1);
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (bus.in_sync && (cnt != '0)) begin
          // Early marker: drop the partial frame, this sample becomes slot 0.
          serr_n = 1'b1;
          cap    = 1'b1;
          wr_idx = '0;
          cnt_n  = CW'(1);
        end else if (!bus.in_sync && (cnt == '0)) begin
          serr_n  = 1'b1;
          cnt_n   = '0;
          state_n = UNLOCKED;
        end else begin
          cap = 1'b1;
          if (cnt == LAST) begin
            cnt_n = '0;
`ifdef VSS_PARTITION_FLOW_TDM_PARITY_EN
            if (par_ok) publish = 1'b1;
            else        perr_n  = 1'b1;
`else
            publish = 1'b1;
`endif
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: state_n = UNLOCKED;
    endcase
  end

  // Shadow frame with the current sample bypassed in, so the last slot
  // publishes on the same edge that captures it. The parity slot index
  // matches no payload slot and leaves the frame untouched.
  always_comb begin
    merged = shadow;
    if (cap) begin
      for (int unsigned s = 0; s < PAY; s++) begin
        if (wr_idx == CW'(s)) merged[s*LANE_W +: LANE_W] = bus.in_data;
      end
    end
  end

  // Channel chunks are contiguous LSB-first, so each channel is a straight
  // slice of the slot vector; pad bits above CH_W are skipped.
  always_comb begin
    pub = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pub[c*CH_W +: CH_W] = merged[c*SPC*LANE_W +: CH_W];
    end
  end

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      state   <= UNLOCKED;
      cnt     <= '0;
      shadow  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      if (cap)     shadow <= merged;
      if (publish) data_q <= pub;
      valid_q <= publish;
      serr_q  <= serr_n;
    end
  end

`ifdef VSS_PARTITION_FLOW_TDM_PARITY_EN
  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_n;
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.locked    = (state == LOCKED);
  assign bus.sync_err  = serr_q;

endmodule

// File: tb/tb_vss_partition_flow_tdm_rx.sv
// Directed bench for vss_partition_flow_tdm_rx: legacy 4x1x1 instance and a
// 2x8 over 3-bit lane instance. Parity expectations follow the build macro
// VSS_PARTITION_FLOW_TDM_PARITY_EN.
module tb_vss_partition_flow_tdm_rx;

`ifdef VSS_PARTITION_FLOW_TDM_PARITY_EN
  localparam int FLA = 5;
  localparam int FLB = 7;
  localparam bit PAR = 1'b1;
`else
  localparam int FLA = 4;
  localparam int FLB = 6;
  localparam bit PAR = 1'b0;
`endif

  logic fastclk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 fastclk = ~fastclk;

  vss_partition_flow_tdm_rx_if #(.NUM_CH(4), .CH_W(1), .LANE_W(1)) if_a ();
  vss_partition_flow_tdm_rx_if #(.NUM_CH(2), .CH_W(8), .LANE_W(3)) if_b ();

  vss_partition_flow_tdm_rx #(.NUM_CH(4), .CH_W(1), .LANE_W(1)) dut_a (
    .fastclk (fastclk),
    .reset   (reset),
    .bus     (if_a.slave)
  );

  vss_partition_flow_tdm_rx #(.NUM_CH(2), .CH_W(8), .LANE_W(3)) dut_b (
    .fastclk (fastclk),
    .reset   (reset),
    .bus     (if_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge fastclk);
    #1;
  endtask

  // One legacy frame; bit i of slots is slot i (= channel i).
  task automatic frame_a(input logic [3:0] slots, input logic par_bit,
                         input logic [3:0] prev, input bit expect_pub);
    for (int i = 0; i < FLA; i++) begin
      if_a.in_sync = (i == 0);
      if_a.in_data = (i < 4) ? slots[i] : par_bit;
      tick;
      if (i == 0) check("a_locked", if_a.locked, 1);
      if (i == FLA - 1) begin
        check("a_valid_end", if_a.out_valid, expect_pub);
        check("a_data_end", if_a.out_data, expect_pub ? slots : prev);
        check("a_perr_end", if_a.parity_err, !expect_pub);
      end else begin
        check("a_valid_mid", if_a.out_valid, 0);
        check("a_data_mid", if_a.out_data, prev);
      end
    end
  endtask

  // One 2x8 frame; slot i is slots[i*3 +: 3].
  task automatic frame_b(input logic [17:0] slots, input logic [15:0] exp,
                         input logic [15:0] prev);
    for (int i = 0; i < FLB; i++) begin
      if_b.in_sync = (i == 0);
      if_b.in_data = (i < 6) ? slots[i*3 +: 3] : {2'b00, ^slots};
      tick;
      if (i == FLB - 1) begin
        check("b_valid_end", if_b.out_valid, 1);
        check("b_data_end", if_b.out_data, exp);
      end else begin
        check("b_valid_mid", if_b.out_valid, 0);
        check("b_data_mid", if_b.out_data, prev);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    if_a.in_sync = 1'b0; if_a.in_data = '0;
    if_b.in_sync = 1'b0; if_b.in_data = '0;
    #12;
    check("rst_a_data", if_a.out_data, 0);
    check("rst_a_valid", if_a.out_valid, 0);
    check("rst_a_locked", if_a.locked, 0);
    check("rst_a_serr", if_a.sync_err, 0);
    check("rst_a_perr", if_a.parity_err, 0);
    check("rst_b_data", if_b.out_data, 0);
    @(negedge fastclk);
    reset = 1'b0;

    // Lane activity without a marker is ignored.
    if_a.in_data = 1'b1;
    tick; tick;
    check("idle_a_locked", if_a.locked, 0);
    check("idle_a_valid", if_a.out_valid, 0);

    // Ch0=A5, ch1=3C; then ch0=5A with a set pad bit, ch1=FF.
    frame_b({3'b000, 3'b111, 3'b100, 3'b010, 3'b100, 3'b101}, 16'h3CA5, 16'h0000);
    frame_b({3'b011, 3'b111, 3'b111, 3'b101, 3'b011, 3'b010}, 16'hFF5A, 16'h3CA5);

    // Back-to-back legacy frames: slots 1,0,1,1 then 0,1,1,0.
    frame_a(4'b1101, ^4'b1101, 4'b0000, 1'b1);
    frame_a(4'b0110, ^4'b0110, 4'b1101, 1'b1);

    if (PAR) begin
      // Wrong parity: no publish, data held, alignment kept.
      frame_a(4'b1101, ~(^4'b1101), 4'b0110, 1'b0);
    end

    // Marker re-asserted at counter 2.
    if_a.in_sync = 1'b1; if_a.in_data = 1'b0; tick;
    if_a.in_sync = 1'b0; if_a.in_data = 1'b0; tick;
    if_a.in_sync = 1'b1; if_a.in_data = 1'b1; tick;
    check("relock_serr", if_a.sync_err, 1);
    check("relock_valid", if_a.out_valid, 0);
    check("relock_locked", if_a.locked, 1);
    check("relock_data", if_a.out_data, 4'b0110);
    for (int i = 1; i < FLA; i++) begin
      if_a.in_sync = 1'b0;
      if_a.in_data = (i < 4) ? 1'b1 : 1'b0;
      tick;
      if (i == 1) check("relock_serr_clr", if_a.sync_err, 0);
    end
    check("relock_pub_valid", if_a.out_valid, 1);
    check("relock_pub_data", if_a.out_data, 4'b1111);

    // Marker missing at the frame boundary.
    if_a.in_sync = 1'b0; if_a.in_data = 1'b1; tick;
    check("miss_serr", if_a.sync_err, 1);
    check("miss_locked", if_a.locked, 0);
    check("miss_valid", if_a.out_valid, 0);
    check("miss_data", if_a.out_data, 4'b1111);
    tick;
    check("miss_serr_clr", if_a.sync_err, 0);
    check("miss_still_unlocked", if_a.locked, 0);

    // Asynchronous reset in slot 2 of the second frame.
    frame_a(4'b0101, ^4'b0101, 4'b1111, 1'b1);
    if_a.in_sync = 1'b1; if_a.in_data = 1'b1; tick;
    if_a.in_sync = 1'b0; if_a.in_data = 1'b0; tick;
    #2 reset = 1'b1;
    #1;
    check("arst_data", if_a.out_data, 0);
    check("arst_valid", if_a.out_valid, 0);
    check("arst_locked", if_a.locked, 0);
    @(negedge fastclk);
    reset = 1'b0;
    frame_a(4'b1011, ^4'b1011, 4'b0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
